// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared single-port data memory (CPU = m0, loader = m1).
// Optional round-robin tie-break enabled by defining DMEM_ARB_RR_EN; otherwise m0 wins ties.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef DMEM_DEPTH
`define DMEM_DEPTH 1024
`endif

module dmem_arbiter #(
  parameter int DATA_W = `DATA_W,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = `DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_lock,
  input  logic              m1_lock,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wd,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rd,
  output logic [DATA_W-1:0] m1_rd,
  output logic              err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [1:0]        dbg_own
);

  // Handshake: a master holds req/we/addr/wd stable until it sees gnt in the same
  // cycle; a granted access completes at the following edge, nothing is queued.

  typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_t;

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  own_t              own;
  own_t              own_nx;
  logic              win0;
  logic              win1;
  logic              any_win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;
  logic [DATA_W-1:0] rd_val;
  logic [ADDR_W-1:0] a_hold;

`ifdef DMEM_ARB_RR_EN
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (win0) begin
      last <= 1'b0;
    end else if (win1) begin
      last <= 1'b1;
    end
  end
`endif

  always_comb begin
    win0   = 1'b0;
    win1   = 1'b0;
    own_nx = own;
    case (own)
      NONE: begin
        if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
          if (last) win0 = 1'b1;
          else      win1 = 1'b1;
`else
          win0 = 1'b1;
`endif
        end else begin
          win0 = m0_req;
          win1 = m1_req;
        end
        if (win0 && m0_lock)      own_nx = OWN0;
        else if (win1 && m1_lock) own_nx = OWN1;
      end
      // An owner that drops req but keeps lock stalls everyone, keeping ownership.
      OWN0: begin
        win0 = m0_req;
        if (!m0_lock) own_nx = NONE;
      end
      OWN1: begin
        win1 = m1_req;
        if (!m1_lock) own_nx = NONE;
      end
      default: own_nx = NONE;
    endcase
  end

  assign any_win  = win0 | win1;
  assign sel_we   = win1 ? m1_we : m0_we;
  assign sel_addr = win1 ? m1_addr : m0_addr;
  assign in_range = ({1'b0, sel_addr} < DEPTH_LIM);
  assign rd_val   = in_range ? mem_rd : '0;

  assign m0_gnt  = win0;
  assign m1_gnt  = win1;
  assign mem_a   = any_win ? sel_addr : a_hold;
  assign mem_wd  = win1 ? m1_wd : m0_wd;
  // Reset gates the write strobe so a write in flight when rst rises is dropped.
  assign mem_we  = any_win & sel_we & in_range & ~rst;
  assign dbg_own = own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own       <= NONE;
      a_hold    <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rd     <= '0;
      m1_rd     <= '0;
      err       <= 1'b0;
    end else begin
      own       <= own_nx;
      a_hold    <= mem_a;
      m0_rvalid <= win0 & ~m0_we;
      m1_rvalid <= win1 & ~m1_we;
      if (win0 && !m0_we) m0_rd <= rd_val;
      if (win1 && !m1_we) m1_rd <= rd_val;
      err       <= any_win & ~in_range;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter sharing the single-port data memory `dmem` between the CPU load/store path (master 0) and the host/DMA loader (master 1). The loader preloads and reads back graph data while the core runs. The block selects one master per cycle and drives `dmem`'s address, write-data and write-enable, and registers read data back to the winner. It supports locked bursts and flags out-of-range addresses.

## Interface
Parameters:
- `DATA_W`, default `` `DATA_W `` (32): memory word width.
- `ADDR_W`, default 16: word-address width, matching the `dmem` port `a`.
- `DEPTH`, default `` `DMEM_DEPTH ``: number of valid words; addresses ≥ `DEPTH` are out of range.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in 1: access request.
- `m0_lock`, `m1_lock` in 1: hold ownership while the lock is high.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in ADDR_W: word address.
- `m0_wd`, `m1_wd` in DATA_W: write data.
- `m0_gnt`, `m1_gnt` out 1: access accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid` out 1: read data valid (registered).
- `m0_rd`, `m1_rd` out DATA_W: registered read data.
- `err` out 1: one-cycle pulse for a granted out-of-range access.
- `mem_a` out ADDR_W, `mem_wd` out DATA_W, `mem_we` out 1: connect to `dmem`.
- `mem_rd` in DATA_W: combinational read data from `dmem`.

## Operation
- Ownership state is `own`, one of `NONE`, `OWN0`, `OWN1`. Reset value is `NONE`.
- Selection in state `NONE`:
  - When only one master requests, that master wins.
  - When both request, the macro-dependent policy decides (see Configuration).
- Selection in state `OWNx`: master x wins whenever `mx_req`=1, and the other master gets no grant. If the owner drops `mx_req` while still holding lock, nobody is granted that cycle and `own` stays `OWNx`.
- State transitions, evaluated at the clock edge:
  - `NONE`→`OWNx` when x is granted with `mx_lock`=1.
  - `OWNx`→`NONE` when `mx_lock`=0.
  - A granted cycle with `mx_lock`=0 is a single access.
- Mux behaviour:
  - `mem_a`, `mem_wd` and `mem_we` follow the winner.
  - `mem_we` = winner's `we` AND the address is in range.
  - With no winner, `mem_we`=0 and `mem_a` holds its last value.
- Reads: on a granted read, `mem_rd` is captured into that master's `mx_rd` at the edge. An out-of-range read captures 0.
- `mx_rd` holds its value until the next granted read by the same master.
- `last` register (round-robin only) records the most recent winner. Reset value is 1, so master 0 wins the first tie.
- Reset values of all outputs:
  - `gnt`: 0, since `own`=NONE and no request is asserted.
  - `rvalid`, `rd`, `err`: 0.
  - `mem_a`: 0.
  - `mem_we`: 0.

## Timing
- Cycle N: master drives req/we/addr/wd and sees `gnt` in the same cycle.
- A write commits at the N→N+1 edge.
- For a read, `rd` is valid and `rvalid`=1 in cycle N+1 only.
- `err` is high in cycle N+1 for a granted out-of-range access.
- An ungranted master must hold its request stable. The arbiter does not queue requests.
- Back-to-back grants are allowed every cycle, giving a throughput of one access per cycle.
- Asynchronous `rst` mid-burst:
  - `own`, `last`, `rvalid` and `err` are cleared immediately.
  - Any pending write in that cycle is dropped because `mem_we` is forced to 0 while `rst` is high.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin tie-break. On a tie in `NONE`, the master other than `last` wins.
- `DMEM_ARB_RR_EN` undefined: fixed priority, master 0 (CPU) always wins ties. The `last` register is not built.
- Lock behaviour is identical in both builds.

## Test plan
- Reset, then write 0x214a0015 to address 0 via m0, then read it via m1.
  - Required: `m1_rvalid`=1 with `m1_rd`=0x214a0015 one cycle after `m1_gnt`.
- Both masters request continuously, unlocked:
  - With `DMEM_ARB_RR_EN`: grants alternate m0, m1, m0, m1.
  - Without it: m0 is granted every cycle and m1 never.
- m1 locks a 4-word write burst to addresses 10..13 while m0 requests throughout.
  - Required: m0 is blocked for all 4 cycles and wins the cycle after `m1_lock` falls.
  - Required: memory readback equals the burst data.
- m0 reads address `DEPTH`, then writes 0xDEADBEEF to `DEPTH`.
  - Required: `err` pulses after each access, `m0_rd`=0, and `mem_we` stays 0.
- Assert `rst` for half a cycle while `own`=OWN1 with a write pending.
  - Required: `own` returns to NONE, the pending write is absent, and m0's next request is granted immediately.
